deemph_lr_sched: RTL and testbench

Sequencer that time-multiplexes one de-emphasis IIR multiply-accumulate datapath between the left and right audio channels of the FM stereo path. It sits between the per-channel demodulated-audio FIFOs and the per-channel de-emphasized output FIFOs. It round-robin arbitrates between channels, runs the three-tap recurrence on a single shared multiplier, and keeps separate x[n-1]/y[n-1] history per channel.

---
 rtl/deemph_pkg.sv | 42 ++++
 rtl/deemph_mac.sv | 45 ++++
 rtl/deemph_lr_sched.sv | 207 ++++++++++++++++++++
 tb/tb_deemph_lr_sched.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/deemph_pkg.sv
// deemph_pkg: shared types, default coefficients and the fixed-point
// requantisation helper for the left/right de-emphasis sequencer.
//   state_t : sequencer FSM states
//   chan_t  : audio channel identifier (also used as the history index)
//   dequant : arithmetic (floor) shift of the MAC accumulator, truncated
//             to the sample width
package deemph_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    MAC0 = 3'd1,
    MAC1 = 3'd2,
    MAC2 = 3'd3,
    WB   = 3'd4
  } state_t;

  typedef enum logic {
    LEFT  = 1'b0,
    RIGHT = 1'b1
  } chan_t;

  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_QUANT_BITS = 10;
  localparam int DEF_B0         = 225;
  localparam int DEF_B1         = 225;
  localparam int DEF_A1         = 574;

  // Two full-width products plus two guard bits: the sum of three
  // products can never overflow.
  localparam int DEF_ACC_WIDTH  = 2 * DEF_DATA_WIDTH + 2;

  // Floor division by 2**qbits followed by truncation to the sample width.
  function automatic logic [DEF_DATA_WIDTH-1:0] dequant(
    input logic signed [DEF_ACC_WIDTH-1:0] acc,
    input int unsigned                     qbits
  );
    logic signed [DEF_ACC_WIDTH-1:0] shifted;
    shifted = acc >>> qbits;
    return shifted[DEF_DATA_WIDTH-1:0];
  endfunction

endpackage

// File: rtl/deemph_mac.sv
// deemph_mac: the single registered signed multiply-accumulator shared by
// both audio channels.
//   clock, reset : system clock, asynchronous active-low reset
//   clear        : when enabled, load a*b instead of accumulating
//   en           : update the accumulator this cycle
//   a, b         : signed multiplicands (coefficient, sample)
//   acc          : registered accumulator, 2*DATA_WIDTH+2 bits signed
module deemph_mac
  import deemph_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic                              clear,
  input  logic                              en,
  input  logic signed [DATA_WIDTH-1:0]      a,
  input  logic signed [DATA_WIDTH-1:0]      b,
  output logic signed [2*DATA_WIDTH+1:0]    acc
);

  localparam int ACC_WIDTH = 2 * DATA_WIDTH + 2;

  logic signed [2*DATA_WIDTH-1:0] w_prod;
  logic signed [ACC_WIDTH-1:0]    w_prod_ext;
  logic signed [ACC_WIDTH-1:0]    r_acc;

  assign w_prod     = a * b;
  assign w_prod_ext = ACC_WIDTH'(w_prod);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_acc <= '0;
    end else if (en) begin
      if (clear) begin
        r_acc <= w_prod_ext;
      end else begin
        r_acc <= r_acc + w_prod_ext;
      end
    end
  end

  assign acc = r_acc;

endmodule

// File: rtl/deemph_lr_sched.sv
// deemph_lr_sched: time-multiplexes one de-emphasis IIR MAC between the
// left and right FM-stereo audio channels.
//   y[n] = (B0*x[n] + B1*x1[c] + A1*y1[c]) >>> QUANT_BITS
// Ports:
//   clock, reset                          : clock, asynchronous active-low reset
//   left_empty/left_dout/left_rd_en       : left input FIFO (first-word fall-through)
//   right_empty/right_dout/right_rd_en    : right input FIFO
//   out_left_full/out_left_din/out_left_wr_en    : left output FIFO
//   out_right_full/out_right_din/out_right_wr_en : right output FIFO
// One sample is issued in IDLE, multiplied over MAC0..MAC2 and written back
// in WB, so rd_en at cycle t is followed by wr_en at cycle t+4.
module deemph_lr_sched
  import deemph_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int QUANT_BITS = DEF_QUANT_BITS,
  parameter int B0         = DEF_B0,
  parameter int B1         = DEF_B1,
  parameter int A1         = DEF_A1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  left_empty,
  input  logic [DATA_WIDTH-1:0] left_dout,
  output logic                  left_rd_en,
  input  logic                  right_empty,
  input  logic [DATA_WIDTH-1:0] right_dout,
  output logic                  right_rd_en,
  input  logic                  out_left_full,
  output logic [DATA_WIDTH-1:0] out_left_din,
  output logic                  out_left_wr_en,
  input  logic                  out_right_full,
  output logic [DATA_WIDTH-1:0] out_right_din,
  output logic                  out_right_wr_en
);

  localparam int ACC_WIDTH = 2 * DATA_WIDTH + 2;
  localparam int NCH       = 2;

  localparam logic signed [DATA_WIDTH-1:0] C_B0 = DATA_WIDTH'(B0);
  localparam logic signed [DATA_WIDTH-1:0] C_B1 = DATA_WIDTH'(B1);
  localparam logic signed [DATA_WIDTH-1:0] C_A1 = DATA_WIDTH'(A1);

  state_t r_state;
  state_t w_state_next;
  chan_t  r_sel;        // channel currently in flight
  chan_t  r_last;       // last channel written back, for round-robin
  chan_t  w_pick;

  logic signed [DATA_WIDTH-1:0] r_x;
  logic signed [DATA_WIDTH-1:0] r_x1 [NCH];
  logic signed [DATA_WIDTH-1:0] r_y1 [NCH];
  logic        [DATA_WIDTH-1:0] r_out_left;
  logic        [DATA_WIDTH-1:0] r_out_right;

  logic                         w_elig_left;
  logic                         w_elig_right;
  logic                         w_any_elig;

  logic                         w_mac_clear;
  logic                         w_mac_en;
  logic signed [DATA_WIDTH-1:0] w_mac_a;
  logic signed [DATA_WIDTH-1:0] w_mac_b;
  logic signed [ACC_WIDTH-1:0]  w_acc;
  logic        [DATA_WIDTH-1:0] w_y;

  // ---------------------------------------------------------------------
  // Arbitration. Output space is checked at issue only: nothing else
  // writes the output FIFOs, so space seen here still exists at WB.
  // ---------------------------------------------------------------------
  assign w_elig_left  = !left_empty  && !out_left_full;
  assign w_elig_right = !right_empty && !out_right_full;
  assign w_any_elig   = w_elig_left || w_elig_right;

  always_comb begin
    w_pick = LEFT;
    if (w_elig_left && w_elig_right) begin
      w_pick = (r_last == RIGHT) ? LEFT : RIGHT;
    end else if (w_elig_right) begin
      w_pick = RIGHT;
    end
  end

  // ---------------------------------------------------------------------
  // Shared MAC
  // ---------------------------------------------------------------------
  deemph_mac #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_mac (
    .clock (clock),
    .reset (reset),
    .clear (w_mac_clear),
    .en    (w_mac_en),
    .a     (w_mac_a),
    .b     (w_mac_b),
    .acc   (w_acc)
  );

  assign w_y = DATA_WIDTH'(dequant(DEF_ACC_WIDTH'(w_acc), QUANT_BITS));

  // ---------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next    = r_state;
    w_mac_clear     = 1'b0;
    w_mac_en        = 1'b0;
    w_mac_a         = '0;
    w_mac_b         = '0;
    left_rd_en      = 1'b0;
    right_rd_en     = 1'b0;
    out_left_wr_en  = 1'b0;
    out_right_wr_en = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_any_elig) begin
          w_state_next = MAC0;
          if (w_pick == LEFT) begin
            left_rd_en = 1'b1;
          end else begin
            right_rd_en = 1'b1;
          end
        end
      end
      MAC0: begin
        w_state_next = MAC1;
        w_mac_clear  = 1'b1;
        w_mac_en     = 1'b1;
        w_mac_a      = C_B0;
        w_mac_b      = r_x;
      end
      MAC1: begin
        w_state_next = MAC2;
        w_mac_en     = 1'b1;
        w_mac_a      = C_B1;
        w_mac_b      = r_x1[r_sel];
      end
      MAC2: begin
        w_state_next = WB;
        w_mac_en     = 1'b1;
        w_mac_a      = C_A1;
        w_mac_b      = r_y1[r_sel];
      end
      WB: begin
        w_state_next = IDLE;
        if (r_sel == LEFT) begin
          out_left_wr_en = 1'b1;
        end else begin
          out_right_wr_en = 1'b1;
        end
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------
  // Sample capture, per-channel history and output hold registers
  // ---------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_sel       <= LEFT;
      r_last      <= RIGHT;
      r_x         <= '0;
      r_x1        <= '{default: '0};
      r_y1        <= '{default: '0};
      r_out_left  <= '0;
      r_out_right <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_any_elig) begin
            r_sel <= w_pick;
            r_x   <= (w_pick == LEFT) ? left_dout : right_dout;
          end
        end
        WB: begin
          r_x1[r_sel] <= r_x;
          r_y1[r_sel] <= w_y;
          r_last      <= r_sel;
          if (r_sel == LEFT) begin
            r_out_left <= w_y;
          end else begin
            r_out_right <= w_y;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // The result must be valid in the same cycle as wr_en, so WB drives the
  // fresh value straight through; otherwise the last written value holds.
  assign out_left_din  = (r_state == WB && r_sel == LEFT)  ? w_y : r_out_left;
  assign out_right_din = (r_state == WB && r_sel == RIGHT) ? w_y : r_out_right;

endmodule

// File: tb/tb_deemph_lr_sched.sv
module tb_deemph_lr_sched;

  logic        clock;
  logic        reset;
  logic        left_empty;
  logic [31:0] left_dout;
  logic        left_rd_en;
  logic        right_empty;
  logic [31:0] right_dout;
  logic        right_rd_en;
  logic        out_left_full;
  logic [31:0] out_left_din;
  logic        out_left_wr_en;
  logic        out_right_full;
  logic [31:0] out_right_din;
  logic        out_right_wr_en;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Input FIFO contents (head at index 0) and recorded handshakes.
  logic [31:0] lq[$];
  logic [31:0] rq[$];
  int          rd_ch[$];
  int          rd_cyc[$];
  int          wr_ch[$];
  int          wr_cyc[$];
  logic [31:0] wr_dat[$];

  deemph_lr_sched dut (
    .clock           (clock),
    .reset           (reset),
    .left_empty      (left_empty),
    .left_dout       (left_dout),
    .left_rd_en      (left_rd_en),
    .right_empty     (right_empty),
    .right_dout      (right_dout),
    .right_rd_en     (right_rd_en),
    .out_left_full   (out_left_full),
    .out_left_din    (out_left_din),
    .out_left_wr_en  (out_left_wr_en),
    .out_right_full  (out_right_full),
    .out_right_din   (out_right_din),
    .out_right_wr_en (out_right_wr_en)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic refresh();
    left_empty  = (lq.size() == 0);
    left_dout   = (lq.size() != 0) ? lq[0] : 32'h0;
    right_empty = (rq.size() == 0);
    right_dout  = (rq.size() != 0) ? rq[0] : 32'h0;
  endtask

  task automatic clear_rec();
    rd_ch.delete();  rd_cyc.delete();
    wr_ch.delete();  wr_cyc.delete();  wr_dat.delete();
  endtask

  // One clock: sample handshakes at the falling edge, apply pops just
  // after the rising edge.
  task automatic tick();
    bit pl, pr;
    @(negedge clock);
    pl = left_rd_en;
    pr = right_rd_en;
    if (pl || pr || out_left_wr_en || out_right_wr_en)
      chk("one_strobe", 32'($countones({pl, pr, out_left_wr_en, out_right_wr_en})), 32'd1);
    if (pl) begin rd_ch.push_back(0); rd_cyc.push_back(cyc); end
    if (pr) begin rd_ch.push_back(1); rd_cyc.push_back(cyc); end
    if (out_left_wr_en) begin
      wr_ch.push_back(0); wr_cyc.push_back(cyc); wr_dat.push_back(out_left_din);
      $display("cycle %0d: write LEFT  %h", cyc, out_left_din);
    end
    if (out_right_wr_en) begin
      wr_ch.push_back(1); wr_cyc.push_back(cyc); wr_dat.push_back(out_right_din);
      $display("cycle %0d: write RIGHT %h", cyc, out_right_din);
    end
    @(posedge clock);
    #1;
    if (pl && lq.size() != 0) void'(lq.pop_front());
    if (pr && rq.size() != 0) void'(rq.pop_front());
    refresh();
    cyc++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic wait_wr(input int n, input int budget);
    int k;
    k = 0;
    while (wr_ch.size() < n && k < budget) begin
      tick();
      k++;
    end
    chk("write_timeout", 32'(wr_ch.size() >= n), 32'd1);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    lq.delete();
    rq.delete();
    out_left_full  = 1'b0;
    out_right_full = 1'b0;
    refresh();
    run(2);
    reset = 1'b1;
    clear_rec();
  endtask

  // Push one sample on a channel and check the single resulting write.
  task automatic one_sample(input string tag, input int ch, input logic [31:0] x,
                            input logic [31:0] y);
    clear_rec();
    if (ch == 0) lq.push_back(x); else rq.push_back(x);
    refresh();
    wait_wr(1, 20);
    if (wr_ch.size() >= 1 && rd_cyc.size() >= 1) begin
      chk({tag, "_chan"}, 32'(wr_ch[0]), 32'(ch));
      chk({tag, "_data"}, wr_dat[0], y);
      chk({tag, "_latency"}, 32'(wr_cyc[0] - rd_cyc[0]), 32'd4);
    end
    run(1);
  endtask

  initial begin
    reset = 1'b0;
    lq.delete();
    rq.delete();
    out_left_full  = 1'b0;
    out_right_full = 1'b0;
    refresh();

    // Reset state
    run(2);
    chk("rst_left_rd_en",  32'(left_rd_en),      32'd0);
    chk("rst_right_rd_en", 32'(right_rd_en),     32'd0);
    chk("rst_left_wr_en",  32'(out_left_wr_en),  32'd0);
    chk("rst_right_wr_en", 32'(out_right_wr_en), 32'd0);
    chk("rst_left_din",    out_left_din,         32'h0);
    chk("rst_right_din",   out_right_din,        32'h0);
    reset = 1'b1;
    run(3);
    chk("idle_no_rd", 32'(rd_ch.size()), 32'd0);

    // Left impulse: 1024*225>>10 = 225; then 589950>>10 = 576
    one_sample("imp1", 0, 32'h0000_0400, 32'h0000_00E1);
    one_sample("imp2", 0, 32'h0000_0400, 32'h0000_0240);
    run(3);
    chk("hold_left_din",  out_left_din,  32'h0000_0240);
    chk("hold_right_din", out_right_din, 32'h0000_0000);

    // Floor rounding, each from a fresh history
    do_reset();
    one_sample("floor_pos1", 0, 32'h0000_0001, 32'h0000_0000);
    do_reset();
    one_sample("floor_neg1", 1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    do_reset();
    one_sample("floor_neg1024", 1, 32'hFFFF_FC00, 32'hFFFF_FF1F);

    // Fairness: 4 samples per side, first tie goes LEFT
    do_reset();
    for (int i = 0; i < 4; i++) begin
      lq.push_back(32'h0000_0400);
      rq.push_back(32'h0000_0800);
    end
    refresh();
    wait_wr(8, 60);
    chk("fair_rd_count", 32'(rd_ch.size()), 32'd8);
    if (rd_ch.size() == 8 && wr_ch.size() >= 8) begin
      for (int i = 0; i < 8; i++) begin
        chk($sformatf("fair_order_%0d", i), 32'(rd_ch[i]), 32'(i % 2));
        chk($sformatf("fair_lat_%0d", i), 32'(wr_cyc[i] - rd_cyc[i]), 32'd4);
      end
      for (int i = 0; i < 7; i++)
        chk($sformatf("fair_gap_%0d", i), 32'(rd_cyc[i+1] - rd_cyc[i]), 32'd5);
      chk("fair_first_left",  wr_dat[0], 32'h0000_00E1);
      chk("fair_first_right", wr_dat[1], 32'h0000_01C2);  // 2048*225>>10 = 450
    end

    // Channel isolation
    do_reset();
    one_sample("iso_left1",  0, 32'h0000_0400, 32'h0000_00E1);
    one_sample("iso_right1", 1, 32'h0000_0400, 32'h0000_00E1);
    one_sample("iso_left2",  0, 32'h0000_0400, 32'h0000_0240);

    // Backpressure on the left output
    do_reset();
    out_left_full = 1'b1;
    lq.push_back(32'h0000_0400);
    lq.push_back(32'h0000_0400);
    rq.push_back(32'h0000_0400);
    rq.push_back(32'h0000_0400);
    refresh();
    run(25);
    chk("bp_rd_count", 32'(rd_ch.size()), 32'd2);
    for (int i = 0; i < rd_ch.size(); i++)
      chk($sformatf("bp_right_only_%0d", i), 32'(rd_ch[i]), 32'd1);
    chk("bp_left_kept", 32'(lq.size()), 32'd2);
    out_left_full = 1'b0;
    clear_rec();
    wait_wr(2, 30);
    if (wr_ch.size() >= 2) begin
      chk("bp_resume_chan0", 32'(wr_ch[0]), 32'd0);
      chk("bp_resume_data0", wr_dat[0], 32'h0000_00E1);
      chk("bp_resume_chan1", 32'(wr_ch[1]), 32'd0);
      chk("bp_resume_data1", wr_dat[1], 32'h0000_0240);
    end

    // Reset during MAC1 discards the in-flight sample
    do_reset();
    lq.push_back(32'h0000_0400);
    refresh();
    run(2);                     // IDLE issue, then MAC0: now in MAC1
    chk("midrst_issued", 32'(rd_ch.size()), 32'd1);
    reset = 1'b0;
    #1;
    chk("midrst_left_wr_en",  32'(out_left_wr_en),  32'd0);
    chk("midrst_right_wr_en", 32'(out_right_wr_en), 32'd0);
    chk("midrst_left_rd_en",  32'(left_rd_en),      32'd0);
    chk("midrst_left_din",    out_left_din,         32'h0);
    chk("midrst_right_din",   out_right_din,        32'h0);
    run(2);
    reset = 1'b1;
    run(10);
    chk("midrst_no_write", 32'(wr_ch.size()), 32'd0);
    one_sample("midrst_next", 0, 32'h0000_0400, 32'h0000_00E1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
